// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: burst initiator for the calculator's synchronous register-file memory.
// Define MEM_ACCESS_READBACK_VERIFY_EN to read back and compare every write beat (sticky err).
module mem_access_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [DEPTH-1:0] req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_last,
  output logic             busy,
  output logic             err,
  output logic             mem_valid,
  output logic             mem_rw,
  output logic [DEPTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_din,
  input  logic [WIDTH-1:0] mem_dout
);
`ifdef MEM_ACCESS_READBACK_VERIFY_EN
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, WVERIFY} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
`endif
  state_t state, state_nxt;
  logic started, rd_p, rd_p_last, accept, last, step;
  logic [DEPTH-1:0] cur_addr;
  logic [LEN_W-1:0] cnt;
  assign last = cnt == '0;
  assign req_ready = state == IDLE && started;
  assign accept = req_valid && req_ready;
  assign busy = state != IDLE;
  assign wr_ready = state == WRITE;
  assign mem_rw = state == WRITE;
  assign mem_din = wr_ready ? wr_data : '0;
  assign mem_addr = mem_valid ? cur_addr : '0;
`ifdef MEM_ACCESS_READBACK_VERIFY_EN
  // vphase splits WVERIFY into its read-strobe cycle (0) and compare cycle (1)
  logic vphase, err_r;
  logic [WIDTH-1:0] chk_data;
  assign mem_valid = state == WRITE || state == READ || (state == WVERIFY && !vphase);
  assign step = state == READ || (state == WVERIFY && vphase);
  assign err = err_r;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vphase <= 1'b0;
      chk_data <= '0;
      err_r <= 1'b0;
    end else begin
      vphase <= state == WVERIFY && !vphase;
      if (state == WRITE) chk_data <= wr_data;
      if (accept) err_r <= 1'b0;
      else if (state == WVERIFY && vphase && mem_dout != chk_data) err_r <= 1'b1;
    end
`else
  assign mem_valid = state == WRITE || state == READ;
  assign step = mem_valid;
  assign err = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? (req_write ? WRITE : READ) : IDLE;
`ifdef MEM_ACCESS_READBACK_VERIFY_EN
      WRITE:   state_nxt = WVERIFY;
      WVERIFY: state_nxt = vphase ? (last ? IDLE : WRITE) : WVERIFY;
`else
      WRITE:   state_nxt = last ? IDLE : WRITE;
`endif
      READ:    state_nxt = last ? DRAIN : READ;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      started <= 1'b0;
      cur_addr <= '0;
      cnt <= '0;
      rd_p <= 1'b0;
      rd_p_last <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_last <= 1'b0;
      rsp_data <= '0;
    end else begin
      state <= state_nxt;
      started <= 1'b1;
      // read data returns one cycle after the strobe and is registered one more cycle
      rd_p <= state == READ;
      rd_p_last <= state == READ && last;
      rsp_valid <= rd_p;
      rsp_last <= rd_p_last;
      if (rd_p) rsp_data <= mem_dout;
      if (accept) begin
        cur_addr <= req_addr;
        cnt <= req_len;
      end else if (step) begin
        cur_addr <= cur_addr + DEPTH'(1);
        cnt <= cnt - LEN_W'(1);
      end
    end
endmodule
